// File: rtl/counter_timer_pkg.sv
// counter_timer_pkg: shared enums for the counter/timer block.
// Optional feature macro used by this slice: COUNTER_TIMER_PRESCALER_EN.
package counter_timer_pkg;

   // Counting behaviour selected at Start_i.
   typedef enum logic [1:0] {
      FREE     = 2'd0,
      ONESHOT  = 2'd1,
      RELOAD   = 2'd2,
      SATURATE = 2'd3
   } mode_t;

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/counter_timer_prescaler.sv
// counter_timer_prescaler: divides the clock into one tick every Div_i+1
// cycles. Only instantiated when COUNTER_TIMER_PRESCALER_EN is defined.
module counter_timer_prescaler
   import counter_timer_pkg::*;
#(
   parameter int PrescaleWidth = 8
) (
   input  logic                     Clk_i,
   input  logic                     Reset_i,
   input  logic                     Restart_i,
   input  logic [PrescaleWidth-1:0] Div_i,
   output logic                     Tick_o
);

   logic [PrescaleWidth-1:0] count_r;

   // Cycle counter: restarts on any command, wraps after reaching Div_i.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         count_r <= {PrescaleWidth{1'b0}};
      end else if (Restart_i) begin
         count_r <= {PrescaleWidth{1'b0}};
      end else if (count_r == Div_i) begin
         count_r <= {PrescaleWidth{1'b0}};
      end else begin
         count_r <= count_r + {{(PrescaleWidth-1){1'b0}}, 1'b1};
      end
   end

   // The tick is a pure decode of the registered count.
   assign Tick_o = (count_r == Div_i);

endmodule

// File: rtl/counter_timer.sv
// counter_timer: up/down counter with FREE/ONESHOT/RELOAD/SATURATE modes,
// IDLE/RUN/DONE control FSM, terminal pulse and sticky overflow flag.
// Define COUNTER_TIMER_PRESCALER_EN to add the PrescaleVal_i port and a tick
// prescaler; without it the counter ticks on every RUN cycle.
module counter_timer
   import counter_timer_pkg::*;
#(
   parameter int Width         = 16,
   parameter int PrescaleWidth = 8
) (
   input  logic                     Clk_i,
   input  logic                     Reset_i,
   input  logic                     Start_i,
   input  logic                     Stop_i,
   input  logic                     Clear_i,
   input  logic [1:0]               Mode_i,
   input  logic                     Direction_i,
   input  logic [Width-1:0]         ReloadVal_i,
   input  logic [Width-1:0]         CompareVal_i,
`ifdef COUNTER_TIMER_PRESCALER_EN
   input  logic [PrescaleWidth-1:0] PrescaleVal_i,
`endif
   output logic [Width-1:0]         D_o,
   output logic                     Running_o,
   output logic                     Terminal_o,
   output logic                     Match_o,
   output logic                     Zero_o,
   output logic                     Overflow_o
);

   localparam logic [Width-1:0] ZERO = {Width{1'b0}};
   localparam logic [Width-1:0] ONES = {Width{1'b1}};
   localparam logic [Width-1:0] ONE  = {{(Width-1){1'b0}}, 1'b1};

   state_t           state_r;
   mode_t            mode_r;
   logic             down_r;
   logic [Width-1:0] count_r;
   logic             running_r;
   logic             terminal_r;
   logic             overflow_r;

   logic             tick_s;
   logic [Width-1:0] term_val_s;
   logic [Width-1:0] next_val_s;
   logic             at_term_s;

`ifdef COUNTER_TIMER_PRESCALER_EN
   logic [PrescaleWidth-1:0] prescale_r;
   logic                     restart_s;

   assign restart_s = Clear_i | Stop_i | Start_i;

   // Divider value is captured only when a Start_i actually takes effect.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         prescale_r <= {PrescaleWidth{1'b0}};
      end else if (Start_i && !Clear_i && !Stop_i) begin
         prescale_r <= PrescaleVal_i;
      end else begin
         prescale_r <= prescale_r;
      end
   end

   counter_timer_prescaler #(
      .PrescaleWidth (PrescaleWidth)
   ) u_prescaler (
      .Clk_i     (Clk_i),
      .Reset_i   (Reset_i),
      .Restart_i (restart_s),
      .Div_i     (prescale_r),
      .Tick_o    (tick_s)
   );
`else
   assign tick_s = 1'b1;
`endif

   // Terminal value and next count follow the direction latched at Start_i.
   always_comb begin
      term_val_s = ONES;
      next_val_s = count_r + ONE;
      if (down_r) begin
         term_val_s = ZERO;
         next_val_s = count_r - ONE;
      end else begin
         term_val_s = ONES;
         next_val_s = count_r + ONE;
      end
   end

   assign at_term_s = (count_r == term_val_s);

   // Control FSM: Clear > Stop > Start > tick; all outputs registered here.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_r    <= IDLE;
         mode_r     <= FREE;
         down_r     <= 1'b0;
         count_r    <= ZERO;
         running_r  <= 1'b0;
         terminal_r <= 1'b0;
         overflow_r <= 1'b0;
      end else if (Clear_i) begin
         state_r    <= IDLE;
         count_r    <= ZERO;
         running_r  <= 1'b0;
         terminal_r <= 1'b0;
         overflow_r <= 1'b0;
      end else if (Stop_i) begin
         state_r    <= IDLE;
         running_r  <= 1'b0;
         terminal_r <= 1'b0;
      end else if (Start_i) begin
         state_r    <= RUN;
         mode_r     <= mode_t'(Mode_i);
         down_r     <= Direction_i;
         count_r    <= ReloadVal_i;
         running_r  <= 1'b1;
         terminal_r <= 1'b0;
      end else begin
         terminal_r <= 1'b0;
         case (state_r)
            RUN: begin
               if (tick_s && at_term_s) begin
                  terminal_r <= 1'b1;
                  case (mode_r)
                     FREE: begin
                        count_r    <= next_val_s;
                        overflow_r <= 1'b1;
                     end
                     ONESHOT: begin
                        state_r   <= DONE;
                        running_r <= 1'b0;
                     end
                     RELOAD: begin
                        count_r <= ReloadVal_i;
                     end
                     SATURATE: begin
                        count_r <= count_r;
                     end
                     default: begin
                        count_r <= count_r;
                     end
                  endcase
               end else if (tick_s) begin
                  count_r <= next_val_s;
               end else begin
                  count_r <= count_r;
               end
            end
            IDLE: begin
               count_r <= count_r;
            end
            DONE: begin
               count_r <= count_r;
            end
            default: begin
               state_r   <= IDLE;
               running_r <= 1'b0;
            end
         endcase
      end
   end

   assign D_o        = count_r;
   assign Running_o  = running_r;
   assign Terminal_o = terminal_r;
   assign Overflow_o = overflow_r;
   assign Match_o    = (count_r == CompareVal_i);
   assign Zero_o     = (count_r == ZERO);

endmodule

// File: tb/tb_counter_timer.sv
// tb_counter_timer: directed self-checking bench for counter_timer (Width=8).
// The prescaler scenario is included when COUNTER_TIMER_PRESCALER_EN is defined.
module tb_counter_timer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       clr;
   logic [1:0] mode;
   logic       dir;
   logic [7:0] reload;
   logic [7:0] cmp;
`ifdef COUNTER_TIMER_PRESCALER_EN
   logic [7:0] prescale;
`endif
   logic [7:0] d;
   logic       running;
   logic       terminal;
   logic       match;
   logic       zero;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   counter_timer #(
      .Width         (8),
      .PrescaleWidth (8)
   ) dut (
      .Clk_i         (clk),
      .Reset_i       (rst),
      .Start_i       (start),
      .Stop_i        (stop),
      .Clear_i       (clr),
      .Mode_i        (mode),
      .Direction_i   (dir),
      .ReloadVal_i   (reload),
      .CompareVal_i  (cmp),
`ifdef COUNTER_TIMER_PRESCALER_EN
      .PrescaleVal_i (prescale),
`endif
      .D_o           (d),
      .Running_o     (running),
      .Terminal_o    (terminal),
      .Match_o       (match),
      .Zero_o        (zero),
      .Overflow_o    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
      mode = 2'd0; dir = 1'b0; reload = 8'h00; cmp = 8'hAA;
`ifdef COUNTER_TIMER_PRESCALER_EN
      prescale = 8'd0;
`endif
      #2 rst = 1'b1;
      #2;
      check("rst_d", d, 8'h00);
      check("rst_zero", zero, 1'b1);
      check("rst_running", running, 1'b0);
      check("rst_terminal", terminal, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      step();
      rst = 1'b0;
      step();

      // FREE up from 0xFE: FE, FF, wrap to 00 with terminal pulse and overflow
      start = 1'b1; mode = 2'd0; dir = 1'b0; reload = 8'hFE;
      step();
      start = 1'b0;
      check("free_load_d", d, 8'hFE);
      check("free_running", running, 1'b1);
      step();
      check("free_ff", d, 8'hFF);
      check("free_ff_term", terminal, 1'b0);
      step();
      check("free_wrap_d", d, 8'h00);
      check("free_wrap_term", terminal, 1'b1);
      check("free_wrap_ovf", overflow, 1'b1);
      step();
      check("free_01", d, 8'h01);
      check("free_term_once", terminal, 1'b0);
      start = 1'b1; reload = 8'h10;
      step();
      start = 1'b0;
      check("free_restart_d", d, 8'h10);
      check("free_ovf_sticky", overflow, 1'b1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clear_d", d, 8'h00);
      check("clear_ovf", overflow, 1'b0);
      check("clear_running", running, 1'b0);

      // ONESHOT down from 3; Mode_i change mid-run must be ignored
      start = 1'b1; mode = 2'd1; dir = 1'b1; reload = 8'd3;
      step();
      start = 1'b0; mode = 2'd0; dir = 1'b0;
      check("os_3", d, 8'd3);
      step();
      check("os_2", d, 8'd2);
      step();
      check("os_1", d, 8'd1);
      step();
      check("os_0", d, 8'd0);
      check("os_0_term", terminal, 1'b0);
      step();
      check("os_done_d", d, 8'd0);
      check("os_done_term", terminal, 1'b1);
      check("os_done_running", running, 1'b0);
      check("os_done_zero", zero, 1'b1);
      step();
      check("os_hold_d", d, 8'd0);
      check("os_single_term", terminal, 1'b0);

      // RELOAD down from 2 with compare 1: 2,1,0,2,1,0
      start = 1'b1; mode = 2'd2; dir = 1'b1; reload = 8'd2; cmp = 8'd1;
      step();
      start = 1'b0;
      check("rl_2a", d, 8'd2);
      check("rl_2a_match", match, 1'b0);
      step();
      check("rl_1a", d, 8'd1);
      check("rl_1a_match", match, 1'b1);
      step();
      check("rl_0a", d, 8'd0);
      step();
      check("rl_2b", d, 8'd2);
      check("rl_2b_term", terminal, 1'b1);
      check("rl_2b_running", running, 1'b1);
      step();
      check("rl_1b", d, 8'd1);
      check("rl_1b_match", match, 1'b1);
      check("rl_1b_term", terminal, 1'b0);
      step();
      check("rl_0b", d, 8'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_d", d, 8'd0);
      check("stop_running", running, 1'b0);
      check("stop_term", terminal, 1'b0);
      step();
      check("stop_hold", d, 8'd0);

      // SATURATE up from 0xFD, terminal pulses repeat while pinned at 0xFF
      start = 1'b1; mode = 2'd3; dir = 1'b0; reload = 8'hFD;
      step();
      start = 1'b0;
      check("sat_fd", d, 8'hFD);
      step();
      check("sat_fe", d, 8'hFE);
      step();
      check("sat_ff", d, 8'hFF);
      step();
      check("sat_hold1", d, 8'hFF);
      check("sat_term1", terminal, 1'b1);
      check("sat_running", running, 1'b1);
      step();
      check("sat_hold2", d, 8'hFF);
      check("sat_term2", terminal, 1'b1);
      stop = 1'b1; clr = 1'b1; start = 1'b1; reload = 8'h55;
      step();
      stop = 1'b0; clr = 1'b0; start = 1'b0;
      check("prio_d", d, 8'h00);
      check("prio_running", running, 1'b0);
      check("prio_term", terminal, 1'b0);
      check("prio_zero", zero, 1'b1);

      // Start coincident with a terminal tick: Start result, no pulse
      start = 1'b1; mode = 2'd3; dir = 1'b0; reload = 8'hFF;
      step();
      reload = 8'h20;
      step();
      start = 1'b0;
      check("st_term_d", d, 8'h20);
      check("st_term_pulse", terminal, 1'b0);

      // Asynchronous reset mid-RUN
      start = 1'b1; mode = 2'd0; dir = 1'b0; reload = 8'h40;
      step();
      start = 1'b0;
      step();
      check("pre_rst_d", d, 8'h41);
      #3 rst = 1'b1;
      #1;
      check("async_rst_d", d, 8'h00);
      check("async_rst_zero", zero, 1'b1);
      check("async_rst_running", running, 1'b0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_d", d, 8'h00);
      check("post_rst_running", running, 1'b0);

`ifdef COUNTER_TIMER_PRESCALER_EN
      // Prescaler: divide by 3, FREE up from 0
      prescale = 8'd2;
      start = 1'b1; mode = 2'd0; dir = 1'b0; reload = 8'h00;
      step();
      start = 1'b0; prescale = 8'd0;
      check("ps_0a", d, 8'd0);
      step();
      check("ps_0b", d, 8'd0);
      step();
      check("ps_0c", d, 8'd0);
      step();
      check("ps_1a", d, 8'd1);
      step();
      check("ps_1b", d, 8'd1);
      step();
      check("ps_1c", d, 8'd1);
      step();
      check("ps_2a", d, 8'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
